// File: rtl/nibble_unswap_packer_if.sv
// Byte-in / word-out stream bundle for the nibble un-swap packer.
// The master side drives bytes in and accepts words out; the slave side is the packer itself.
interface nibble_unswap_packer_if;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [4:0]   out_count;
   logic         out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_last
   );
endinterface

// File: rtl/nibble_unswap_packer.sv
// Restores nibble-swapped bytes and packs them MSB-first into 128-bit words,
// with an accumulator that parks a finished word while the output register is still occupied.
module nibble_unswap_packer (
   input logic                   clk,
   input logic                   rst_n,
   nibble_unswap_packer_if.slave bus
);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [127:0] acc_data;
   logic [3:0]   fill_cnt;
   logic [4:0]   held_count;
   logic         held_last;
   logic [7:0]   restored;
   logic [127:0] merged_data;
   logic [4:0]   word_count;
   logic         accept;
   logic         complete;
   logic         out_free;
   logic         load_new;
   logic         load_held;
   logic         park;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // The incoming byte drops into lane fill_cnt, counting lanes down from the top of the word.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      complete    = 1'b0;
      load_new    = 1'b0;
      load_held   = 1'b0;
      park        = 1'b0;
      restored    = {bus.in_data[3:0], bus.in_data[7:4]};
      merged_data = acc_data | ({restored, 120'd0} >> {fill_cnt, 3'b000});
      word_count  = {1'b0, fill_cnt} + 5'd1;
      out_free    = !bus.out_valid || bus.out_ready;
      case (state)
         FILL: begin
            accept   = bus.in_valid;
            complete = bus.in_valid && (bus.in_last || fill_cnt == 4'd15);
            load_new = complete && out_free;
            park     = complete && !out_free;
            if (park) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            load_held = bus.out_ready;
            if (bus.out_ready) begin
               state_next = FILL;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   assign bus.in_ready = (state == FILL);

   // A parked word keeps its byte count and last flag beside it, since fill_cnt restarts at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_data   <= '0;
         fill_cnt   <= '0;
         held_count <= '0;
         held_last  <= 1'b0;
      end else if (load_held) begin
         acc_data <= '0;
      end else if (accept) begin
         if (park) begin
            acc_data   <= merged_data;
            held_count <= word_count;
            held_last  <= bus.in_last;
            fill_cnt   <= '0;
         end else if (complete) begin
            acc_data <= '0;
            fill_cnt <= '0;
         end else begin
            acc_data <= merged_data;
            fill_cnt <= fill_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_count <= '0;
         bus.out_last  <= 1'b0;
      end else if (load_held) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= acc_data;
         bus.out_count <= held_count;
         bus.out_last  <= held_last;
      end else if (load_new) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= merged_data;
         bus.out_count <= word_count;
         bus.out_last  <= bus.in_last;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nibble_unswap_packer.sv
// Directed and randomized bench for nibble_unswap_packer, scored against a byte-list model
// that rebuilds each expected word from the accepted bytes.
module tb_nibble_unswap_packer;

   typedef struct packed {
      logic [127:0] data;
      logic [4:0]   count;
      logic         last;
   } word_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;
   int   fails = 0;

   nibble_unswap_packer_if bus ();

   nibble_unswap_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] restoreByte(input logic [7:0] raw);
      int v;
      v = (int'(raw) % 16) * 16 + int'(raw) / 16;
      return 8'(v);
   endfunction

   function automatic logic [127:0] packWord(input logic [7:0] b [0:15], input int n);
      logic [127:0] w;
      w = '0;
      for (int k = 0; k < n; k++) begin
         w = w | ({120'd0, b[k]} << (8 * (15 - k)));
      end
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the byte's transfer edge.
   task automatic applyStimulus(input logic [7:0] d, input logic last, output int waitCycles);
      waitCycles = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(negedge clk);
      while (!bus.in_ready && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!bus.in_ready) begin
         checkOutput("in_ready_timeout", bus.in_ready, 1'b1);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model and scoreboard, sampled on the falling edge.
   logic [7:0]   partialBytes [0:15];
   int           partialCount = 0;
   word_t        expWords [$];
   int           wordsSeen = 0;
   int           lastSeenCount = 0;
   logic         heldPrev = 1'b0;
   logic [127:0] prevData;
   logic [4:0]   prevCount;
   logic         prevLast;

   always @(negedge clk) begin
      word_t w;
      if (!rst_n) begin
         partialCount = 0;
         expWords.delete();
      end else begin
         if (heldPrev) begin
            checkOutput("stall_valid", bus.out_valid, 1'b1);
            checkOutput("stall_data", bus.out_data, prevData);
            checkOutput("stall_count", bus.out_count, prevCount);
            checkOutput("stall_last", bus.out_last, prevLast);
         end
         if (bus.out_valid && bus.out_ready) begin
            wordsSeen++;
            lastSeenCount = int'(bus.out_count);
            checkOutput("word_expected", bus.out_valid, expWords.size() != 0);
            if (expWords.size() != 0) begin
               w = expWords.pop_front();
               checkOutput("word_data", bus.out_data, w.data);
               checkOutput("word_count", bus.out_count, w.count);
               checkOutput("word_last", bus.out_last, w.last);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            partialBytes[partialCount] = restoreByte(bus.in_data);
            partialCount++;
            if (bus.in_last || partialCount == 16) begin
               w.data  = packWord(partialBytes, partialCount);
               w.count = 5'(partialCount);
               w.last  = bus.in_last;
               expWords.push_back(w);
               partialCount = 0;
            end
         end
      end
      heldPrev  = rst_n && bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
      prevCount = bus.out_count;
      prevLast  = bus.out_last;
   end

   initial begin
      int           wc;
      int           seenBefore;
      logic         took;
      time          t0;
      logic [7:0]   rawA [0:31];
      logic [7:0]   resA [0:15];
      logic [7:0]   resB [0:15];
      logic [127:0] wordA;
      logic [127:0] wordB;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("[TB] reset released");
      checkOutput("reset_out_valid", bus.out_valid, 1'b0);
      checkOutput("reset_out_data", bus.out_data, 128'd0);
      checkOutput("reset_out_count", bus.out_count, 5'd0);
      checkOutput("reset_out_last", bus.out_last, 1'b0);
      checkOutput("reset_in_ready", bus.in_ready, 1'b1);

      // Full word of known bytes
      for (int k = 0; k < 16; k++) begin
         applyStimulus((k < 15) ? 8'((k + 1) * 16) : 8'h01, 1'b0, wc);
      end
      checkOutput("full_valid", bus.out_valid, 1'b1);
      checkOutput("full_data", bus.out_data, 128'h0102030405060708090A0B0C0D0E0F10);
      checkOutput("full_count", bus.out_count, 5'd16);
      checkOutput("full_last", bus.out_last, 1'b0);
      idleCycles(2);

      // Partial word closed by last
      applyStimulus(8'h21, 1'b0, wc);
      applyStimulus(8'h43, 1'b1, wc);
      checkOutput("partial_valid", bus.out_valid, 1'b1);
      checkOutput("partial_data", bus.out_data, {16'h1234, 112'd0});
      checkOutput("partial_count", bus.out_count, 5'd2);
      checkOutput("partial_last", bus.out_last, 1'b1);
      idleCycles(2);

      // Backpressure over two words
      bus.out_ready = 1'b0;
      for (int k = 0; k < 32; k++) rawA[k] = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
         resA[k] = restoreByte(rawA[k]);
         resB[k] = restoreByte(rawA[k + 16]);
      end
      wordA = packWord(resA, 16);
      wordB = packWord(resB, 16);
      for (int k = 0; k < 32; k++) applyStimulus(rawA[k], 1'b0, wc);
      checkOutput("bp_in_ready_low", bus.in_ready, 1'b0);
      checkOutput("bp_first_word", bus.out_data, wordA);
      idleCycles(3);
      checkOutput("bp_still_valid", bus.out_valid, 1'b1);
      checkOutput("bp_still_first", bus.out_data, wordA);
      checkOutput("bp_still_blocked", bus.in_ready, 1'b0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_second_valid", bus.out_valid, 1'b1);
      checkOutput("bp_second_word", bus.out_data, wordB);
      checkOutput("bp_in_ready_back", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("bp_drained", bus.out_valid, 1'b0);

      // Continuous streaming of three words
      idleCycles(2);
      t0 = $time;
      for (int k = 0; k < 48; k++) begin
         applyStimulus(8'($urandom), 1'b0, wc);
         checkOutput("stream_no_stall", 32'(wc), 32'd0);
         checkOutput("stream_valid_pulse", bus.out_valid, (k % 16) == 15);
      end
      checkOutput("stream_cycles", 64'(($time - t0) / 10), 64'd48);
      idleCycles(2);

      // Reset in the middle of a word
      for (int k = 0; k < 7; k++) applyStimulus(8'($urandom), 1'b0, wc);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("midreset_valid", bus.out_valid, 1'b0);
      checkOutput("midreset_in_ready", bus.in_ready, 1'b1);
      seenBefore = wordsSeen;
      for (int k = 0; k < 16; k++) applyStimulus(8'($urandom), 1'b0, wc);
      idleCycles(2);
      checkOutput("midreset_words", 32'(wordsSeen - seenBefore), 32'd1);
      checkOutput("midreset_count", 32'(lastSeenCount), 32'd16);

      // Reset while a word is parked
      bus.out_ready = 1'b0;
      for (int k = 0; k < 32; k++) applyStimulus(8'($urandom), 1'b0, wc);
      checkOutput("holdreset_blocked", bus.in_ready, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("holdreset_valid", bus.out_valid, 1'b0);
      checkOutput("holdreset_data", bus.out_data, 128'd0);
      checkOutput("holdreset_in_ready", bus.in_ready, 1'b1);
      seenBefore = wordsSeen;
      bus.out_ready = 1'b1;
      idleCycles(3);
      checkOutput("holdreset_no_word", 32'(wordsSeen - seenBefore), 32'd0);

      // Completing a word on the same edge the previous one drains
      bus.out_ready = 1'b0;
      for (int k = 0; k < 32; k++) rawA[k] = 8'($urandom);
      for (int k = 0; k < 16; k++) resB[k] = restoreByte(rawA[k + 16]);
      wordB = packWord(resB, 16);
      for (int k = 0; k < 31; k++) applyStimulus(rawA[k], 1'b0, wc);
      bus.out_ready = 1'b1;
      applyStimulus(rawA[31], 1'b0, wc);
      checkOutput("simul_valid", bus.out_valid, 1'b1);
      checkOutput("simul_data", bus.out_data, wordB);
      checkOutput("simul_in_ready", bus.in_ready, 1'b1);
      idleCycles(2);

      // Randomized traffic with random consumer stalls
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         took = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (took || !bus.in_valid) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = 8'($urandom);
            bus.in_last  = ($urandom_range(0, 7) == 0);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = 1'b1;
      applyStimulus(8'($urandom), 1'b1, wc);
      idleCycles(4);
      checkOutput("random_all_words_out", 32'(expWords.size()), 32'd0);
      checkOutput("random_final_idle", bus.out_valid, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/nibble_unswap_packer.md
NIBBLE_UNSWAP_PACKER -- requirements
Module: nibble_unswap_packer

Interface
REQ-001 The block SHALL have no parameters: byte width is fixed at 8, word width at 128, bytes per word at 16.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge only.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low, sampled on rising clk.
REQ-004 Port in_valid, input, 1 bit: in_data and in_last are valid this cycle.
REQ-005 Port in_ready, output, 1 bit: block accepts input this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-006 Port in_data, input, 8 bits: a nibble-swapped byte, with the low nibble of the original byte in bits [7:4].
REQ-007 Port in_last, input, 1 bit: the accepted byte closes the current word, even if the word is partial.
REQ-008 Port out_valid, output, 1 bit: out_data, out_count and out_last are valid.
REQ-009 Port out_ready, input, 1 bit: consumer accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-010 Port out_data, output, 128 bits: the un-swapped packed word.
REQ-011 Port out_count, output, 5 bits: number of valid bytes in out_data, from 1 to 16.
REQ-012 Port out_last, output, 1 bit: the word was closed by in_last.

Function
REQ-013 Each accepted byte SHALL be restored as {in_data[3:0], in_data[7:4]} before storage.
REQ-014 Packing SHALL be MSB-first: byte k of a word (k = 0..15, in arrival order) SHALL occupy bits [127-8k : 120-8k].
REQ-015 Unfilled byte lanes of a partial word SHALL read as 0.
REQ-016 The block SHALL contain an accumulator (data register plus 4-bit fill counter) and one output register (out_*).
REQ-017 A word SHALL complete on the accepted byte that either brings the fill counter to 16 or carries in_last=1; a single byte with in_last=1 gives out_count=1.
REQ-018 A completed word SHALL move to the output register on the same clock edge when the output register is empty or is being drained that cycle (out_valid and out_ready both 1).
REQ-019 In that case out_valid SHALL be 1 in the cycle after the completing byte is accepted, giving a latency of 1 cycle.
REQ-020 If a completed word cannot move, the block SHALL enter state HOLD and keep the word in the accumulator.
REQ-021 State machine: FILL (in_ready=1) and HOLD (in_ready=0).
REQ-022 FILL -> HOLD: a word completes while the output register is full and is not being drained.
REQ-023 HOLD -> FILL: the output register drains; the held word SHALL load into the output register on that same edge.
REQ-024 The fill counter SHALL clear when a word completes, wrapping 15 -> 0 on a full word.
REQ-025 Sustained throughput SHALL be 1 byte per cycle while out_ready=1.
REQ-026 Output outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 out_valid SHALL fall after a drain only if no new word loads on that edge.
REQ-028 in_ready SHALL depend only on registered state, with no combinational path from out_ready.
REQ-029 A byte arriving while in_valid=0 SHALL be ignored; in_last is meaningful only on a transfer.

Reset
REQ-030 When rst_n=0 at a rising clk, the block SHALL clear: state=FILL, fill counter=0, accumulator=0.
REQ-031 The same reset SHALL drive out_valid=0, out_data=0, out_count=0, out_last=0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n is released.
REQ-033 Reset mid-word or in HOLD SHALL discard all partial and pending data with no spurious out_valid.

Verification
REQ-034 Full word: send 16 bytes, values 0x10, 0x20, ... 0xF0, 0x01, with out_ready=1 and in_last=0 on all bytes.
  -> One cycle after the 16th byte: out_valid=1, out_data=128'h0102...0F10, out_count=16, out_last=0.
REQ-035 Partial word: send 0x21, 0x43 with in_last=1 on the second byte.
  -> out_data=128'h1234 followed by 112 zero bits, out_count=2, out_last=1.
REQ-036 Backpressure: hold out_ready=0 and stream 32 bytes.
  -> in_ready falls the cycle after byte 32 completes; the first word stays stable.
  -> Raising out_ready gives word 1 then word 2, back to back; in_ready returns to 1.
REQ-037 Streaming: 48 bytes continuous with out_ready=1.
  -> Exactly 3 words, with out_valid pulses spaced 16 cycles apart and no input stall.
REQ-038 Mid-word reset: after 7 bytes, assert rst_n=0 for 1 cycle, then send 16 bytes.
  -> The only output is one word made from the new 16 bytes, with out_count=16.
REQ-039 Wrap and simultaneity: complete a word in the same cycle the previous word drains.
  -> The new word loads with no bubble: out_valid stays 1 and out_data updates on that edge.
